// File: rtl/prbs_sched_pkg.sv
// prbs_sched_pkg: shared types, constants and LFSR helpers for the PRBS
// burst scheduler (x^4 + x^3 + 1 Fibonacci LFSR).
package prbs_sched_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int LFSR_W = 4;

    // Feedback taps of x^4 + x^3 + 1, as bit positions of the state register.
    localparam int TAP_HI = 3;
    localparam int TAP_LO = 2;

    // The all-zero state is a lock-up state, so a zero seed is replaced.
    localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 4'b0001;

    // One LFSR step: shift left, feed the tap XOR into bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
    endfunction

    // Seed sanitiser: never allow the LFSR to be loaded with zero.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? ZERO_SEED_SUB : s;
    endfunction

endpackage

// File: rtl/prbs_lfsr4.sv
// prbs_lfsr4: 4-bit Fibonacci LFSR with synchronous load and step enable.
// Load has priority over step; the value holds when neither is asserted.
module prbs_lfsr4
    import prbs_sched_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RST_VAL = 4'b1010
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    input  logic              step,
    output logic [LFSR_W-1:0] q
);

    // LFSR state: reload, step or hold.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!rst) begin
            q <= RST_VAL;
        end else if (load) begin
            q <= load_val;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/prbs_sched.sv
// prbs_sched: round-robin scheduler sharing one 4-bit PRBS generator among
// NREQ requesters. Grants bursts of req_len+1 words, tags each word with the
// owner ID and defers reseeds until the generator is idle.
// Optional feature: define PRBS_SCHED_STATS_EN to add the saturating
// word_cnt[15:0] output counting delivered words.
module prbs_sched
    import prbs_sched_pkg::*;
#(
    parameter int                NREQ     = 4,
    parameter int                LEN_W    = 4,
    parameter logic [LFSR_W-1:0] SEED_DEF = 4'b1010,
    localparam int               ID_W     = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*LEN_W-1:0] req_len,
    input  logic                  reseed,
    input  logic [LFSR_W-1:0]     seed_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  out_valid,
    output logic [LFSR_W-1:0]     out_data,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_last,
`ifdef PRBS_SCHED_STATS_EN
    output logic [15:0]           word_cnt,
`endif
    output logic                  busy
);

    // Counter holds up to 2^LEN_W words, so it needs one extra bit.
    localparam int CNT_W = LEN_W + 1;

    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pend;
    logic [LFSR_W-1:0] r_seed;
    logic [NREQ-1:0]   r_gnt;
    logic              r_valid;
    logic [LFSR_W-1:0] r_data;
    logic [ID_W-1:0]   r_id;
    logic              r_last;
    logic              r_busy;

    logic              w_found;
    logic [ID_W-1:0]   w_win_id;
    logic [LEN_W-1:0]  w_win_len;
    logic              w_load;
    logic [LFSR_W-1:0] w_load_val;
    logic              w_step;
    logic [LFSR_W-1:0] w_q;

    // Reseed is serviced in IDLE; a fresh pulse overrides the pending seed.
    assign w_load     = (r_state == ST_IDLE) && (reseed || r_pend);
    assign w_load_val = seed_fix(reseed ? seed_in : r_seed);
    assign w_step     = (r_state == ST_RUN);

    prbs_lfsr4 #(
        .RST_VAL (SEED_DEF)
    ) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .step     (w_step),
        .q        (w_q)
    );

    // Round-robin search starting one past the last winner.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        w_found  = 1'b0;
        w_win_id = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
                w_found  = 1'b1;
                w_win_id = ID_W'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_win_len = req_len[int'(w_win_id)*LEN_W +: LEN_W];

    // Scheduler FSM with burst counter, pending reseed and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= ID_W'(NREQ - 1);
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_seed  <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_id    <= '0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (reseed || r_pend) begin
                        r_pend <= 1'b0;
                        r_busy <= 1'b0;
                    end else if (w_found) begin
                        r_state <= ST_RUN;
                        r_gnt   <= NREQ'(1) << w_win_id;
                        r_id    <= w_win_id;
                        r_ptr   <= w_win_id;
                        r_cnt   <= {1'b0, w_win_len} + CNT_W'(1);
                        r_valid <= 1'b1;
                        r_data  <= w_q;
                        r_last  <= (w_win_len == '0);
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (reseed) begin
                        r_pend <= 1'b1;
                        r_seed <= seed_in;
                    end
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_valid <= 1'b0;
                        r_data  <= '0;
                        r_id    <= '0;
                        r_last  <= 1'b0;
                        r_busy  <= reseed || r_pend;
                    end else begin
                        r_data <= lfsr_next(w_q);
                        r_last <= (r_cnt == CNT_W'(2));
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PRBS_SCHED_STATS_EN
    logic [15:0] r_word_cnt;

    // Saturating count of delivered words, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word_cnt <= '0;
        end else if (r_valid && (r_word_cnt != 16'hFFFF)) begin
            r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign word_cnt = r_word_cnt;
`endif

    assign gnt       = r_gnt;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_id    = r_id;
    assign out_last  = r_last;
    assign busy      = r_busy;

endmodule

// File: tb/tb_prbs_sched.sv
// tb_prbs_sched: directed scenarios plus randomized traffic for prbs_sched,
// checked against a behavioural burst-level model of the scheduler.
module tb_prbs_sched;

    localparam int NREQ  = 4;
    localparam int LEN_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic                  reseed;
    logic [3:0]            seed_in;
    logic [NREQ-1:0]       gnt;
    logic                  out_valid;
    logic [3:0]            out_data;
    logic [1:0]            out_id;
    logic                  out_last;
    logic                  busy;
`ifdef PRBS_SCHED_STATS_EN
    logic [15:0]           word_cnt;
`endif

    prbs_sched #(
        .NREQ     (NREQ),
        .LEN_W    (LEN_W),
        .SEED_DEF (4'b1010)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_len   (req_len),
        .reseed    (reseed),
        .seed_in   (seed_in),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
`ifdef PRBS_SCHED_STATS_EN
        .word_cnt  (word_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the generator value, whether a burst is running, how many words
    // remain, its owner, the round-robin pointer and any deferred seed.
    bit         m_run;
    int         m_left;
    int         m_owner;
    int         m_ptr;
    bit         m_pend;
    logic [3:0] m_pseed;
    logic [3:0] m_lfsr;
    int         m_wc;

    function automatic logic [3:0] prbs_next(input logic [3:0] v);
        logic [3:0] s;
        s = v << 1;
        s[0] = v[3] ^ v[2];
        return s;
    endfunction

    task automatic model_reset();
        m_run   = 1'b0;
        m_left  = 0;
        m_owner = 0;
        m_ptr   = NREQ - 1;
        m_pend  = 1'b0;
        m_pseed = 4'd0;
        m_lfsr  = 4'b1010;
        m_wc    = 0;
    endtask

    // Apply one clock edge worth of behaviour using the current inputs.
    task automatic model_edge();
        logic [3:0] s;
        bit         found;
        int         i;
        if (m_run) begin
            if (m_wc < 65535) m_wc++;
            m_lfsr = prbs_next(m_lfsr);
            m_left--;
            if (reseed) begin
                m_pend  = 1'b1;
                m_pseed = seed_in;
            end
            if (m_left == 0) m_run = 1'b0;
        end else if (reseed || m_pend) begin
            s      = reseed ? seed_in : m_pseed;
            m_lfsr = (s == 4'd0) ? 4'b0001 : s;
            m_pend = 1'b0;
        end else if (req != '0) begin
            found = 1'b0;
            for (int k = 1; k <= NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (!found && req[i]) begin
                    found   = 1'b1;
                    m_owner = i;
                    m_ptr   = i;
                    m_left  = int'(req_len[i*LEN_W +: LEN_W]) + 1;
                    m_run   = 1'b1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("gnt",       32'(gnt),       m_run ? (32'd1 << m_owner) : 32'd0);
        check("out_valid", 32'(out_valid), 32'(m_run));
        check("out_data",  32'(out_data),  m_run ? 32'(m_lfsr) : 32'd0);
        check("out_id",    32'(out_id),    m_run ? 32'(m_owner) : 32'd0);
        check("out_last",  32'(out_last),  32'(m_run && (m_left == 1)));
        check("busy",      32'(busy),      32'(m_run || m_pend));
`ifdef PRBS_SCHED_STATS_EN
        check("word_cnt",  32'(word_cnt),  32'(m_wc));
`endif
    endtask

    // One clock: model follows the edge, outputs checked on the falling edge,
    // the reseed pulse is withdrawn afterwards.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
        reseed = 1'b0;
    endtask

    // Asynchronous reset asserted from a falling edge.
    task automatic apply_reset();
        rst = 1'b0;
        model_reset();
        #1;
        check("rst_gnt",   32'(gnt),       32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_burst(input int id, input int len);
        req = '0;
        req[id] = 1'b1;
        req_len[id*LEN_W +: LEN_W] = 4'(len);
        cycle();
        req = '0;
        repeat (len + 1) cycle();
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int order[$];

    initial begin
        req     = '0;
        req_len = '0;
        reseed  = 1'b0;
        seed_in = 4'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Single 3-word burst from requester 0.
        req = 4'b0001;
        req_len[3:0] = 4'd2;
        cycle();
        check("t1_w0", 32'(out_data), 32'hA);
        req = '0;
        cycle();
        check("t1_w1", 32'(out_data), 32'h5);
        cycle();
        check("t1_w2", 32'(out_data), 32'hB);
        check("t1_last", 32'(out_last), 32'd1);
        cycle();
        check("t1_idle", 32'(out_valid), 32'd0);

        // All requesters held with one-word bursts: strict rotation.
        @(negedge clk);
        apply_reset();
        req     = 4'b1111;
        req_len = '0;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (gnt != '0) order.push_back(int'(out_id));
        end
        check("t2_ngrants", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check("t2_order", 32'(order[i]), 32'(exp_order[i]));
        req = '0;
        cycle();

        // Zero seed in IDLE while a request is waiting.
        reseed  = 1'b1;
        seed_in = 4'd0;
        req     = 4'b0010;
        req_len[7:4] = 4'd1;
        cycle();
        check("t3_nogrant", 32'(gnt), 32'd0);
        cycle();
        check("t3_gnt", 32'(gnt), 32'h2);
        check("t3_w0", 32'(out_data), 32'h1);
        req = '0;
        cycle();
        check("t3_w1", 32'(out_data), 32'h2);
        cycle();

        // Reseed mid-burst is deferred past the burst.
        req = 4'b0001;
        req_len[3:0] = 4'd3;
        cycle();
        req = '0;
        cycle();
        reseed  = 1'b1;
        seed_in = 4'b1100;
        cycle();
        check("t4_busy_run", 32'(busy), 32'd1);
        cycle();
        cycle();
        check("t4_busy_pend", 32'(busy), 32'd1);
        req = 4'b0001;
        req_len[3:0] = 4'd0;
        cycle();
        check("t4_nogrant", 32'(gnt), 32'd0);
        cycle();
        check("t4_w0", 32'(out_data), 32'hC);
        req = '0;
        cycle();

        // Reset during word 2 of a 4-word burst.
        req = 4'b0100;
        req_len[11:8] = 4'd3;
        cycle();
        req = '0;
        cycle();
        apply_reset();
        req     = 4'b1111;
        req_len = '0;
        cycle();
        check("t5_gnt", 32'(gnt), 32'h1);
        check("t5_w0", 32'(out_data), 32'hA);
        req = '0;
        cycle();

        // Randomized traffic: requests held until granted, random reseeds.
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && ($urandom_range(3, 0) == 0)) begin
                    req[i] = 1'b1;
                    req_len[i*LEN_W +: LEN_W] = 4'($urandom_range(15, 0));
                end
            end
            reseed  = ($urandom_range(15, 0) == 0);
            seed_in = 4'($urandom_range(15, 0));
            cycle();
            if (m_run) req[m_owner] = 1'b0;
        end
        req = '0;
        repeat (20) cycle();

`ifdef PRBS_SCHED_STATS_EN
        apply_reset();
        run_burst(0, 1);
        run_burst(1, 0);
        run_burst(2, 15);
        check("st_cnt19", 32'(word_cnt), 32'd19);
        dut.r_word_cnt = 16'hFFFE;
        m_wc = 65534;
        run_burst(3, 2);
        check("st_sat", 32'(word_cnt), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_sched.md
# prbs_sched

Round-robin scheduler that shares one 4-bit PRBS generator among NREQ requesters. Each requester asks for a burst of 1–16 pseudo-random words. The block arbitrates, steps the LFSR once per delivered word and tags each word with the owner's ID. It also handles reseeding, deferring it so that a burst in progress is never corrupted. It sits between the PRBS datapath and its consumers, such as test-pattern and scrambler clients.

## Interface
- NREQ, 4: number of requesters (2–8)
- LEN_W, 4: burst-length field width; a burst is req_len+1 words
- SEED_DEF, 4'b1010: LFSR value after reset
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (one clock domain)
- req  in  NREQ  per-requester request level; held until gnt
- req_len  in  NREQ*LEN_W  packed burst lengths; slice i belongs to requester i
- reseed  in  1  single-cycle pulse requesting an LFSR reload
- seed_in  in  4  seed value, sampled in the same cycle as reseed
- gnt  out  NREQ  one-hot grant, high for the whole burst
- out_valid  out  1  out_data is a valid word
- out_data  out  4  PRBS word
- out_id  out  $clog2(NREQ)  index of the burst owner
- out_last  out  1  final word of the burst
- busy  out  1  a burst is in progress or a reseed is pending

## Operation
- FSM states: IDLE, RUN.
- **LFSR**
  - Fibonacci LFSR, polynomial x^4+x^3+1: next = {q[2:0], q[3]^q[2]}.
  - Holds its value in IDLE.
  - Steps once per out_valid word.
- **IDLE**
  - A pending reseed is serviced first and uses that cycle. The LFSR loads seed_in, or 4'b0001 if seed_in is 0 (the all-zero state locks up). No grant is issued in that cycle.
  - Otherwise, if req is non-zero: round-robin search starting at ptr+1 mod NREQ. The first set bit wins.
  - On a win: register gnt and out_id, load the counter with req_len slice + 1, set ptr to the winner, go to RUN.
- **RUN**
  - out_valid=1 and out_data=LFSR current value; the LFSR steps at the edge.
  - Counter decrements each cycle. out_last=1 when counter==1.
  - After the last word: gnt, out_valid and out_last all drop and the FSM returns to IDLE.
- **Request sampling:** req is sampled only in IDLE. Deasserting req mid-burst does not abort the burst.
- **Reseed during RUN:** latch seed_in and set a pending flag. The burst continues unaffected; the seed is applied in the next IDLE cycle.
- **Reseed priority:** a reseed arriving while one is already pending overwrites the pending seed (last one wins).
- **busy** = (state==RUN) | pending.
- **Reset values:** state IDLE, LFSR=SEED_DEF, ptr=NREQ-1 (so requester 0 wins first), pending=0, every output 0.
- **Reset mid-burst:** all outputs clear asynchronously and the burst is discarded.

## Timing
- req seen at edge E in IDLE → gnt, out_valid and first word all visible after E.
- A burst occupies exactly req_len+1 consecutive cycles.
- At least one IDLE cycle separates bursts.
- Back-to-back throughput is (L+1)/(L+2).
- A reseed adds one more IDLE cycle.
- All outputs are registered.

## Configuration
- **PRBS_SCHED_STATS_EN defined:**
  - Adds output word_cnt[15:0], a count of words delivered.
  - It saturates at 16'hFFFF and is cleared only by rst.
- **Undefined:** no port and no counter logic.

## Structure
- **Package prbs_sched_pkg:**
  - state enum
  - LFSR width (4)
  - tap positions
  - zero-seed substitute 4'b0001
- **Sub-module prbs_lfsr4:**
  - ports: clk, rst, load, load_val, step, q
  - parameterised reset value
  - instantiated once
- Arbiter, counter and FSM live in the top module.

## Test plan
- Reset, then req=0001 with len 2 → gnt=0001; out_data 1010, 0101, 1011 with out_id=0; out_last on the third word; one IDLE cycle follows.
- req=1111, all lengths 0, held → one-word bursts granted to 0, 1, 2, 3, 0 in that order, with one IDLE cycle between grants.
- Pulse reseed with seed_in=0 in IDLE while req=0010 → LFSR=0001. The grant comes one cycle later and its words are 0001, 0010, …
- Pulse reseed with seed_in=1100 mid-burst → remaining burst words continue the old sequence and busy stays high. The next burst starts with 1100.
- Assert rst low during word 2 of a 4-word burst → gnt, out_valid and busy go 0 immediately. After release, the next burst starts at 1010 and requester 0 has priority.
- With PRBS_SCHED_STATS_EN: three bursts of 2, 1 and 16 words → word_cnt=19. Force the counter to 16'hFFFE and deliver 3 more words → it holds at 16'hFFFF.
